// File: rtl/action_sched_pkg.sv
// action_sched_pkg: command encoding, button bit indices and FSM states for action_scheduler
package action_sched_pkg;
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_PUNCH = 3'd3,
    CMD_KICK  = 3'd4
  } cmd_t;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_PUNCH = 2;
  localparam int BTN_KICK  = 3;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus level debounce for one button (debounce built only with ACTION_SCHED_DEBOUNCE_EN)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic state
);
  logic s1, s2;
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 2 ** CNT_W) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES does not fit in CNT_W");
  end
  // bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2, s1} <= 2'b00;
    else {s2, s1} <= {s1, raw};
`ifdef ACTION_SCHED_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;
  // accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (s2 == state) cnt <= '0;
    else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      state <= s2;
    end else cnt <= cnt + 1'b1;
`else
  assign state = s2;
`endif
endmodule

// File: rtl/action_scheduler.sv
// action_scheduler: turns debounced buttons into one valid/ready fighter command per frame, with attack latching and cooldown
// Build option: define ACTION_SCHED_DEBOUNCE_EN to enable per-button debounce counters.
module action_scheduler
  import action_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ATTACK_COOLDOWN = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       frame_tick,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd,
  output logic [3:0] btn_state,
  output logic       busy
);
  logic [3:0] btn_state_q, rise;
  logic pend_punch, pend_kick, hs, atk;
  logic [CNT_W-1:0] cool;
  state_t state;
  cmd_t pick;
  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(btn_raw[i]), .state(btn_state[i])
    );
  end
  assign rise = btn_state & ~btn_state_q;
  assign hs   = cmd_valid & cmd_ready;
  assign atk  = hs & (cmd == CMD_PUNCH || cmd == CMD_KICK);
  assign busy = cool != '0;
  // kick beats punch beats a single held move; both directions held cancel out
  assign pick = pend_kick ? CMD_KICK
              : pend_punch ? CMD_PUNCH
              : (btn_state[BTN_LEFT] & ~btn_state[BTN_RIGHT]) ? CMD_LEFT
              : (btn_state[BTN_RIGHT] & ~btn_state[BTN_LEFT]) ? CMD_RIGHT
              : CMD_NONE;
  // latch attack presses outside cooldown; an accepted attack consumes both
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_state_q <= '0;
      pend_punch  <= 1'b0;
      pend_kick   <= 1'b0;
    end else begin
      btn_state_q <= btn_state;
      if (atk) begin
        pend_punch <= 1'b0;
        pend_kick  <= 1'b0;
      end else if (!busy) begin
        if (rise[BTN_PUNCH]) pend_punch <= 1'b1;
        if (rise[BTN_KICK]) pend_kick <= 1'b1;
      end
    end
  // attack cooldown: reload on accepted attack, count down to zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cool <= '0;
    else if (atk) cool <= CNT_W'(ATTACK_COOLDOWN);
    else if (busy) cool <= cool - 1'b1;
  // command FSM: sample a choice on frame_tick, hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end else if (state == IDLE) begin
      if (frame_tick && pick != CMD_NONE) begin
        state     <= ISSUE;
        cmd_valid <= 1'b1;
        cmd       <= pick;
      end
    end else if (cmd_ready) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NONE;
    end
endmodule

// File: tb/tb_action_scheduler.sv
// tb_action_scheduler: directed self-checking bench for action_scheduler
module tb_action_scheduler;
`ifdef ACTION_SCHED_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst_n = 0, frame_tick = 0, cmd_ready = 0, cmd_valid, busy;
  logic [3:0] btn_raw = 0, btn_state;
  logic [2:0] cmd;
  int vecs = 0, errs = 0;

  action_scheduler #(.DEBOUNCE_CYCLES(4), .ATTACK_COOLDOWN(10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .frame_tick(frame_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .btn_state(btn_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_tick = 1;
    tick();
    frame_tick = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(3);
    vecs++;
    if ({cmd_valid, cmd, btn_state, busy} !== 9'b0) begin
      errs++;
      $display("FAIL reset_values: valid=%b cmd=%0d btn=%b busy=%b, want all 0", cmd_valid, cmd, btn_state, busy);
    end
    rst_n = 1;
    tick(2);
  endtask

  task automatic test_debounce();
`ifdef ACTION_SCHED_DEBOUNCE_EN
    btn_raw = 4'b0100;
    tick(3);
    btn_raw = 4'b0000;
    tick(8);
    vecs++;
    if (btn_state !== 4'b0000) begin
      errs++;
      $display("FAIL glitch_filtered: btn_state=%b, want 0000", btn_state);
    end
`endif
    btn_raw = 4'b0100;
    tick(LAT - 1);
    vecs++;
    if (btn_state !== 4'b0000) begin
      errs++;
      $display("FAIL debounce_early: btn_state=%b, want 0000", btn_state);
    end
    tick();
    vecs++;
    if (btn_state !== 4'b0100) begin
      errs++;
      $display("FAIL debounce_latency: btn_state=%b, want 0100", btn_state);
    end
  endtask

  task automatic test_attack();
    tick();
    frame();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
      errs++;
      $display("FAIL punch_issue: valid=%b cmd=%0d, want 1/3", cmd_valid, cmd);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
        errs++;
        $display("FAIL punch_hold_%0d: valid=%b cmd=%0d, want 1/3", i, cmd_valid, cmd);
      end
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    vecs++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL punch_accept: valid=%b cmd=%0d busy=%b, want 0/0/1", cmd_valid, cmd, busy);
    end
  endtask

  task automatic test_cooldown();
    btn_raw = 4'b1000;
    for (int i = 1; i < 10; i++) begin
      tick();
      vecs++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL busy_hold_%0d: busy=%b, want 1", i, busy);
      end
    end
    tick();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL busy_end: busy=%b, want 0", busy);
    end
    frame();
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL kick_blocked: valid=%b cmd=%0d, want valid 0", cmd_valid, cmd);
    end
    btn_raw = 4'b0000;
    tick(LAT + 2);
    btn_raw = 4'b1000;
    tick(LAT + 2);
    frame();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
      errs++;
      $display("FAIL kick_issue: valid=%b cmd=%0d, want 1/4", cmd_valid, cmd);
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    btn_raw = 4'b0000;
    tick(14);
  endtask

  task automatic test_priority();
    btn_raw = 4'b1110;
    tick(LAT + 2);
    frame();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
      errs++;
      $display("FAIL prio_kick: valid=%b cmd=%0d, want 1/4", cmd_valid, cmd);
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    btn_raw = 4'b0010;
    tick();
    frame();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
      errs++;
      $display("FAIL prio_right_after: valid=%b cmd=%0d, want 1/2", cmd_valid, cmd);
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    btn_raw = 4'b0000;
    tick(LAT + 12);
  endtask

  task automatic test_moves();
    btn_raw = 4'b0011;
    tick(LAT + 2);
    frame();
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL both_dirs: valid=%b cmd=%0d, want valid 0", cmd_valid, cmd);
    end
    btn_raw = 4'b0001;
    tick(LAT + 2);
    cmd_ready = 1;
    frame_tick = 1;
    tick();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
      errs++;
      $display("FAIL left_issue: valid=%b cmd=%0d, want 1/1", cmd_valid, cmd);
    end
    tick();
    frame_tick = 0;
    vecs++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
      errs++;
      $display("FAIL left_accept: valid=%b cmd=%0d, want 0/0", cmd_valid, cmd);
    end
    tick();
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL tick_not_queued: valid=%b cmd=%0d, want valid 0", cmd_valid, cmd);
    end
    cmd_ready = 0;
  endtask

  task automatic test_reset_mid();
    frame();
    vecs++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
      errs++;
      $display("FAIL mid_setup: valid=%b cmd=%0d, want 1/1", cmd_valid, cmd);
    end
    rst_n = 0;
    btn_raw = 4'b0000;
    #1;
    vecs++;
    if ({cmd_valid, cmd, btn_state, busy} !== 9'b0) begin
      errs++;
      $display("FAIL reset_async: valid=%b cmd=%0d btn=%b busy=%b, want all 0", cmd_valid, cmd, btn_state, busy);
    end
    tick(2);
    rst_n = 1;
    tick(5);
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_cmd: valid=%b cmd=%0d, want valid 0", cmd_valid, cmd);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_attack();
    test_cooldown();
    test_priority();
    test_moves();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
